ppu_oam_dma: RTL and testbench

- Bus-master DMA engine that copies sprite data from system RAM into the picoPPU OAM.
- Performs the CPU-side write cycles the PPU register interface expects: one OAM ADDR write (reg 3), then a stream of OAM DATA writes (reg 4).
- Sits beside the 65C02 on the PPU register port and halts the CPU (RDY low) while it owns the bus.

---
 rtl/ppu_pkg.sv | 34 +++
 rtl/ppu_bus_writer.sv | 61 ++++++
 rtl/ppu_oam_dma.sv | 128 ++++++++++++
 tb/tb_ppu_oam_dma.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared picoPPU bus definitions: register selects, DMA/bus-writer state types, timing minimums.
// Defining PPU_OAM_DMA_VBLANK_WAIT_EN adds the WAIT_VB DMA state.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_ADDR     = 3'd1;
  localparam logic [2:0] REG_DATA     = 3'd2;
  localparam logic [2:0] REG_OAM_ADDR = 3'd3;
  localparam logic [2:0] REG_OAM_DATA = 3'd4;

  localparam int unsigned MIN_STROBE = 2;
  localparam int unsigned MIN_GAP    = 4;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_ADDR_WR,
    DMA_RD_REQ,
    DMA_RD_WAIT,
    DMA_WR_DATA,
    DMA_DONE
`ifdef PPU_OAM_DMA_VBLANK_WAIT_EN
    , DMA_WAIT_VB
`endif
  } dma_state_t;

  typedef enum logic [2:0] {
    BW_IDLE,
    BW_SETUP,
    BW_STROBE,
    BW_HOLD,
    BW_GAP
  } bw_phase_t;

endpackage

// File: rtl/ppu_bus_writer.sv
// One-shot PPU register write sequencer: SETUP, STROBE, HOLD, GAP, started by go while idle.
module ppu_bus_writer
  import ppu_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic go,
  output logic idle,
  output logic gap_tail,
  output logic cs,
  output logic we_b,
  output logic data_oe
);

  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] GAP_PENULT  = 8'(GAP_CYCLES - 2);

  bw_phase_t  phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q <= BW_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = '0;
    unique case (phase_q)
      BW_IDLE:   if (go) phase_d = BW_SETUP;
      BW_SETUP:  phase_d = BW_STROBE;
      BW_STROBE: begin
        if (cnt_q == STROBE_LAST) phase_d = BW_HOLD;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      BW_HOLD:   phase_d = BW_GAP;
      BW_GAP: begin
        if (cnt_q == GAP_LAST) phase_d = BW_IDLE;
        else                   cnt_d   = cnt_q + 8'd1;
      end
      default:   phase_d = BW_IDLE;
    endcase
  end

  assign idle     = (phase_q == BW_IDLE);
  // Raised one cycle before the bus is free so a master can overlap its next request.
  assign gap_tail = (phase_q == BW_GAP) && (cnt_q == GAP_PENULT);
  assign cs       = (phase_q == BW_STROBE);
  assign we_b     = (phase_q != BW_STROBE);
  assign data_oe  = (phase_q == BW_SETUP) || (phase_q == BW_STROBE) || (phase_q == BW_HOLD);

endmodule

// File: rtl/ppu_oam_dma.sv
// OAM DMA bus master: one reg-3 address write, then RAM bytes streamed into reg 4, CPU halted meanwhile.
// Defining PPU_OAM_DMA_VBLANK_WAIT_EN holds the transfer in WAIT_VB until v_blank.
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [7:0]  oam_start,
  input  logic [7:0]  len_words,
  input  logic        v_blank,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        ppu_cs,
  output logic        ppu_we_b,
  output logic [2:0]  ppu_reg_sel,
  output logic [7:0]  ppu_data,
  output logic        ppu_data_oe,
  output logic        cpu_halt,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LAT_LAST = 8'(RD_LATENCY - 1);

  dma_state_t  state_q, state_d;
  logic [15:0] addr_q;
  logic [8:0]  byte_q;
  logic [7:0]  lat_q;
  logic        wr_go, wr_idle, wr_gap_tail;
  logic        rd_last;

  ppu_bus_writer #(
    .STROBE_CYCLES(STROBE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_writer (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (wr_go),
    .idle    (wr_idle),
    .gap_tail(wr_gap_tail),
    .cs      (ppu_cs),
    .we_b    (ppu_we_b),
    .data_oe (ppu_data_oe)
  );

  assign rd_last = (state_q == DMA_RD_WAIT) && (lat_q == LAT_LAST);

  // Leaving on gap_tail lets RD_REQ share the writer's last GAP cycle.
  always_comb begin
    state_d = state_q;
    wr_go   = 1'b0;
    unique case (state_q)
      DMA_IDLE: begin
`ifdef PPU_OAM_DMA_VBLANK_WAIT_EN
        if (start) state_d = DMA_WAIT_VB;
`else
        if (start) state_d = DMA_ADDR_WR;
`endif
      end
`ifdef PPU_OAM_DMA_VBLANK_WAIT_EN
      DMA_WAIT_VB: if (v_blank) state_d = DMA_ADDR_WR;
`endif
      DMA_ADDR_WR: begin
        wr_go = wr_idle;
        if (wr_gap_tail) state_d = DMA_RD_REQ;
      end
      DMA_RD_REQ:  state_d = DMA_RD_WAIT;
      DMA_RD_WAIT: begin
        if (rd_last) begin
          wr_go   = 1'b1;
          state_d = DMA_WR_DATA;
        end
      end
      DMA_WR_DATA: if (wr_gap_tail) state_d = (byte_q == '0) ? DMA_DONE : DMA_RD_REQ;
      DMA_DONE:    state_d = DMA_IDLE;
      default:     state_d = DMA_IDLE;
    endcase
  end

  // A byte count of 0 means 512: the first decrement wraps it to 511.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= DMA_IDLE;
      addr_q      <= '0;
      byte_q      <= '0;
      lat_q       <= '0;
      ppu_data    <= '0;
      ppu_reg_sel <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DMA_IDLE && start) begin
        addr_q      <= src_addr;
        byte_q      <= {len_words, 1'b0};
        ppu_reg_sel <= REG_OAM_ADDR;
        ppu_data    <= oam_start;
      end
      if (state_q == DMA_RD_REQ)
        lat_q <= '0;
      else if (state_q == DMA_RD_WAIT && !rd_last)
        lat_q <= lat_q + 8'd1;
      if (rd_last) begin
        ppu_data    <= mem_rdata;
        ppu_reg_sel <= REG_OAM_DATA;
        addr_q      <= addr_q + 16'd1;
        byte_q      <= byte_q - 9'd1;
      end
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = (state_q == DMA_RD_REQ);
  assign busy     = (state_q != DMA_IDLE) && (state_q != DMA_DONE);
  assign cpu_halt = busy;
  assign done     = (state_q == DMA_DONE);

`ifndef PPU_OAM_DMA_VBLANK_WAIT_EN
  logic unused_v_blank;
  assign unused_v_blank = v_blank;
`endif

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Bench for ppu_oam_dma: random RAM contents, a PPU-side bus monitor and a transfer-level expectation model.
module tb_ppu_oam_dma;

  localparam int unsigned STROBE      = 4;
  localparam int unsigned GAP         = 4;
  localparam int unsigned RDLAT       = 1;
  localparam int unsigned BYTE_PERIOD = 2 + RDLAT + STROBE + GAP;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        v_blank = 1'b0;
  logic [15:0] src_addr = '0;
  logic [7:0]  oam_start = '0;
  logic [7:0]  len_words = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        ppu_cs, ppu_we_b, ppu_data_oe, cpu_halt, busy, done;
  logic [2:0]  ppu_reg_sel;
  logic [7:0]  ppu_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  ram [0:65535];

  always #5 clk = ~clk;

  ppu_oam_dma #(
    .STROBE_CYCLES(STROBE),
    .GAP_CYCLES   (GAP),
    .RD_LATENCY   (RDLAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .oam_start  (oam_start),
    .len_words  (len_words),
    .v_blank    (v_blank),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .ppu_cs     (ppu_cs),
    .ppu_we_b   (ppu_we_b),
    .ppu_reg_sel(ppu_reg_sel),
    .ppu_data   (ppu_data),
    .ppu_data_oe(ppu_data_oe),
    .cpu_halt   (cpu_halt),
    .busy       (busy),
    .done       (done)
  );

  // RAM with one-cycle read latency; junk on the data lines when not reading
  always @(posedge clk) mem_rdata <= mem_rd ? ram[mem_addr] : 8'($urandom);

  // PPU-side observer: records completed writes, reads, strobe starts and protocol violations
  logic [10:0] wr_q [$];
  logic [15:0] rd_q [$];
  int unsigned st_q [$];
  int unsigned viol = 0, done_cnt = 0, done_bad = 0, cyc = 0;
  int unsigned str_len = 0, oe_len = 0, idle_len = 0;
  logic        mon_act = 1'b0, prev_act = 1'b0, prev_oe = 1'b0, prev_cs = 1'b0, have_prev = 1'b0;
  logic [2:0]  prev_sel = '0;
  logic [7:0]  prev_data = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      prev_act = 1'b0; prev_oe = 1'b0; prev_cs = 1'b0; have_prev = 1'b0;
      str_len = 0; oe_len = 0; idle_len = 0;
    end else begin
      mon_act = ppu_cs && !ppu_we_b;
      if (mem_rd) rd_q.push_back(mem_addr);
      if (done) begin
        done_cnt++;
        if (busy || cpu_halt) done_bad++;
      end
      if ((ppu_data_oe || mem_rd) && !cpu_halt) viol++;
      if (ppu_cs && !ppu_data_oe) viol++;
      if (ppu_cs == ppu_we_b) viol++;
      if (ppu_data_oe && prev_oe && (ppu_data != prev_data || ppu_reg_sel != prev_sel)) viol++;
      if (mon_act && !prev_act) begin
        if (!prev_oe || prev_cs) viol++;
        if (have_prev && idle_len < GAP) viol++;
        st_q.push_back(cyc);
        str_len = 0;
      end
      if (mon_act) str_len++;
      if (!mon_act && prev_act) begin
        if (str_len != STROBE) viol++;
        if (!ppu_data_oe) viol++;
        wr_q.push_back({ppu_reg_sel, ppu_data});
        have_prev = 1'b1;
        idle_len  = 0;
      end
      if (!mon_act) idle_len++;
      if (ppu_data_oe) oe_len++;
      else begin
        if (prev_oe && oe_len != STROBE + 2) viol++;
        oe_len = 0;
      end
      prev_act = mon_act; prev_oe = ppu_data_oe; prev_cs = ppu_cs;
      prev_data = ppu_data; prev_sel = ppu_reg_sel;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_dma(input logic [15:0] src, input logic [7:0] oam, input logic [7:0] len,
                         input bit poke);
    int unsigned w0, r0, s0, v0, d0, db0, nbytes, t, bad;
    w0 = wr_q.size(); r0 = rd_q.size(); s0 = st_q.size();
    v0 = viol; d0 = done_cnt; db0 = done_bad;
    nbytes = (len == 8'd0) ? 512 : 2 * int'(len);
    src_addr = src; oam_start = oam; len_words = len; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("halt_on_start", cpu_halt, 1);
    check("busy_on_start", busy, 1);
    t = 0;
    while (!done && t < 20000) begin
      start = poke && (t == 15);
      if (poke && t == 15) begin
        src_addr = src + 16'h1234; len_words = len + 8'd3; oam_start = ~oam;
      end
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    repeat (GAP + 2) @(posedge clk);
    #1;
    check("n_writes", wr_q.size() - w0, nbytes + 1);
    check("addr_write", (wr_q.size() > w0) ? wr_q[w0] : 11'h0, {3'd3, oam});
    check("first_data", (wr_q.size() > w0 + 1) ? wr_q[w0 + 1] : 11'h0, {3'd4, ram[src]});
    bad = 0;
    for (int i = 0; i < int'(nbytes); i++)
      if (w0 + 1 + i >= wr_q.size() || wr_q[w0 + 1 + i] !== {3'd4, ram[16'(src + i)]}) bad++;
    check("data_writes_bad", bad, 0);
    check("n_reads", rd_q.size() - r0, nbytes);
    bad = 0;
    for (int i = 0; i < int'(nbytes); i++)
      if (r0 + i >= rd_q.size() || rd_q[r0 + i] !== 16'(src + i)) bad++;
    check("read_addr_bad", bad, 0);
    bad = 0;
    for (int i = 1; i < int'(nbytes); i++)
      if (s0 + 1 + i >= st_q.size() || st_q[s0 + 1 + i] - st_q[s0 + i] != BYTE_PERIOD) bad++;
    check("byte_period_bad", bad, 0);
    check("bus_violations", viol - v0, 0);
    check("done_count", done_cnt - d0, 1);
    check("done_flags", done_bad - db0, 0);
    check("idle_busy", busy, 0);
    check("idle_halt", cpu_halt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned wb, t;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);

    // Reset, with a start pulse that coincides with it
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("rst_cs", ppu_cs, 0);
    check("rst_we_b", ppu_we_b, 1);
    check("rst_oe", ppu_data_oe, 0);
    check("rst_reg_sel", ppu_reg_sel, 0);
    check("rst_data", ppu_data, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_halt", cpu_halt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("start_in_reset_ignored", busy, 0);

    // Single word from 0x0200
    ram[16'h0200] = 8'hAB;
    ram[16'h0201] = 8'hCD;
    run_dma(16'h0200, 8'h00, 8'd1, 1'b0);

    // 256 words with the source address wrapping
    run_dma(16'hFF00, 8'h10, 8'd0, 1'b0);

    // Random transfers, half with a start pulse while busy
    for (int k = 0; k < 4; k++)
      run_dma(16'($urandom), 8'($urandom), 8'($urandom_range(1, 6)), k[0]);

    // Reset during the strobe of data byte 5
    wb = wr_q.size();
    src_addr = 16'h0300; oam_start = 8'h20; len_words = 8'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (!(wr_q.size() - wb == 5 && ppu_cs) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("reached_byte5_strobe", ppu_cs, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort_cs", ppu_cs, 0);
    check("abort_we_b", ppu_we_b, 1);
    check("abort_oe", ppu_data_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_halt", cpu_halt, 0);
    check("abort_mem_rd", mem_rd, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort_writes_kept", wr_q.size() - wb, 5);
    run_dma(16'($urandom), 8'($urandom), 8'($urandom_range(1, 6)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
